// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data-memory port between the pipeline (port 0) and an
// auxiliary requester (port 1), returning read data one cycle later with bounded port 1 wait.
module dmem_arbiter #(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 64,
   parameter int MEM_ADDR_W = 10,
   parameter int MAX_WAIT   = 4
) (
   input  logic                  i_clk,
   input  logic                  i_arst,

   input  logic                  i_p0_req,
   input  logic                  i_p0_we,
   input  logic [ADDR_WIDTH-1:0] i_p0_addr,
   input  logic [DATA_WIDTH-1:0] i_p0_wdata,
   output logic                  o_p0_stall,
   output logic                  o_p0_rvalid,
   output logic [DATA_WIDTH-1:0] o_p0_rdata,

   input  logic                  i_p1_req,
   input  logic                  i_p1_we,
   input  logic [ADDR_WIDTH-1:0] i_p1_addr,
   input  logic [DATA_WIDTH-1:0] i_p1_wdata,
   output logic                  o_p1_gnt,
   output logic                  o_p1_rvalid,
   output logic [DATA_WIDTH-1:0] o_p1_rdata,

   output logic                  o_mem_we,
   output logic [MEM_ADDR_W-1:0] o_mem_addr,
   output logic [DATA_WIDTH-1:0] o_mem_wdata,
   input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

   localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

   logic                  grant0_s;
   logic                  grant1_s;
   logic [3:0]            wait_q;
   logic [3:0]            wait_d;
   logic                  p0_rvalid_q;
   logic                  p0_rvalid_d;
   logic [DATA_WIDTH-1:0] p0_rdata_q;
   logic [DATA_WIDTH-1:0] p0_rdata_d;
   logic                  p1_rvalid_q;
   logic                  p1_rvalid_d;
   logic [DATA_WIDTH-1:0] p1_rdata_q;
   logic [DATA_WIDTH-1:0] p1_rdata_d;

   // Addresses wrap: bits above the memory index are deliberately dropped.
   logic                  unused_addr_s;
   assign unused_addr_s = ^{i_p0_addr[ADDR_WIDTH-1:MEM_ADDR_W], i_p1_addr[ADDR_WIDTH-1:MEM_ADDR_W]};

   // Grant: port 0 has priority unless port 1 has already lost MAX_WAIT cycles in a row.
   always_comb begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
      case ({i_p0_req, i_p1_req})
         2'b10: grant0_s = 1'b1;
         2'b01: grant1_s = 1'b1;
         2'b11: begin
            if (wait_q == MAX_WAIT_C) begin
               grant1_s = 1'b1;
            end else begin
               grant0_s = 1'b1;
            end
         end
         default: begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
         end
      endcase
   end

   // Memory port mux; idle cycles drive zeros so the bus is quiet.
   always_comb begin
      o_mem_we    = 1'b0;
      o_mem_addr  = '0;
      o_mem_wdata = '0;
      if (grant0_s) begin
         o_mem_we    = i_p0_we;
         o_mem_addr  = i_p0_addr[MEM_ADDR_W-1:0];
         o_mem_wdata = i_p0_wdata;
      end else if (grant1_s) begin
         o_mem_we    = i_p1_we;
         o_mem_addr  = i_p1_addr[MEM_ADDR_W-1:0];
         o_mem_wdata = i_p1_wdata;
      end else begin
         o_mem_we    = 1'b0;
         o_mem_addr  = '0;
         o_mem_wdata = '0;
      end
   end

   assign o_p0_stall = i_p0_req & ~grant0_s;
   assign o_p1_gnt   = grant1_s;

   // Starvation counter: counts consecutive lost port 1 cycles, saturating at MAX_WAIT.
   always_comb begin
      wait_d = 4'd0;
      if (i_p1_req && !grant1_s) begin
         if (wait_q >= MAX_WAIT_C) begin
            wait_d = MAX_WAIT_C;
         end else begin
            wait_d = wait_q + 4'd1;
         end
      end else begin
         wait_d = 4'd0;
      end
   end

   // Read return: a granted read captures memory data; the other port's data holds.
   always_comb begin
      p0_rvalid_d = grant0_s & ~i_p0_we;
      p1_rvalid_d = grant1_s & ~i_p1_we;
      p0_rdata_d  = p0_rdata_q;
      p1_rdata_d  = p1_rdata_q;
      if (p0_rvalid_d) begin
         p0_rdata_d = i_mem_rdata;
      end else begin
         p0_rdata_d = p0_rdata_q;
      end
      if (p1_rvalid_d) begin
         p1_rdata_d = i_mem_rdata;
      end else begin
         p1_rdata_d = p1_rdata_q;
      end
   end

   // State registers; reset drops any in-flight read return.
   always_ff @(posedge i_clk or negedge i_arst) begin
      if (!i_arst) begin
         wait_q      <= 4'd0;
         p0_rvalid_q <= 1'b0;
         p0_rdata_q  <= '0;
         p1_rvalid_q <= 1'b0;
         p1_rdata_q  <= '0;
      end else begin
         wait_q      <= wait_d;
         p0_rvalid_q <= p0_rvalid_d;
         p0_rdata_q  <= p0_rdata_d;
         p1_rvalid_q <= p1_rvalid_d;
         p1_rdata_q  <= p1_rdata_d;
      end
   end

   assign o_p0_rvalid = p0_rvalid_q;
   assign o_p0_rdata  = p0_rdata_q;
   assign o_p1_rvalid = p1_rvalid_q;
   assign o_p1_rdata  = p1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter with a behavioural data memory.
module tb_dmem_arbiter;

   localparam int MAX_WAIT = 4;

   logic        clk;
   logic        i_arst;
   logic        i_p0_req, i_p0_we, i_p1_req, i_p1_we;
   logic [63:0] i_p0_addr, i_p0_wdata, i_p1_addr, i_p1_wdata;
   logic        o_p0_stall, o_p0_rvalid, o_p1_gnt, o_p1_rvalid, o_mem_we;
   logic [63:0] o_p0_rdata, o_p1_rdata, o_mem_wdata, i_mem_rdata;
   logic [9:0]  o_mem_addr;

   int          chk_cnt = 0;
   int          err_cnt = 0;
   int          wait_m  = 0;
   logic        exp_rv0, exp_rv1;
   logic [63:0] last0, last1;
   logic [63:0] q0[$];
   logic [63:0] q1[$];
   logic [63:0] model_mem [0:1023];
   logic [1023:0] model_wr;
   logic [63:0] sram [0:1023];
   logic [1023:0] written;

   dmem_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .MEM_ADDR_W(10), .MAX_WAIT(MAX_WAIT)) dut (
      .i_clk(clk), .i_arst(i_arst),
      .i_p0_req(i_p0_req), .i_p0_we(i_p0_we), .i_p0_addr(i_p0_addr), .i_p0_wdata(i_p0_wdata),
      .o_p0_stall(o_p0_stall), .o_p0_rvalid(o_p0_rvalid), .o_p0_rdata(o_p0_rdata),
      .i_p1_req(i_p1_req), .i_p1_we(i_p1_we), .i_p1_addr(i_p1_addr), .i_p1_wdata(i_p1_wdata),
      .o_p1_gnt(o_p1_gnt), .o_p1_rvalid(o_p1_rvalid), .o_p1_rdata(o_p1_rdata),
      .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
      .i_mem_rdata(i_mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] pattern(input logic [9:0] a);
      return 64'h0000_0000_0000_DEBD ^ {54'd0, a};
   endfunction

   // Behavioural memory: writes land mid-cycle when the arbiter outputs are settled.
   assign i_mem_rdata = written[o_mem_addr] ? sram[o_mem_addr] : pattern(o_mem_addr);
   initial begin
      written = '0;
      forever begin
         @(negedge clk);
         if (o_mem_we === 1'b1) begin
            sram[o_mem_addr]    = o_mem_wdata;
            written[o_mem_addr] = 1'b1;
         end
      end
   end

   function automatic logic [63:0] model_read(input logic [9:0] a);
      return model_wr[a] ? model_mem[a] : pattern(a);
   endfunction

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_returns();
      check_eq("p0_rvalid", {63'd0, o_p0_rvalid}, {63'd0, exp_rv0});
      check_eq("p1_rvalid", {63'd0, o_p1_rvalid}, {63'd0, exp_rv1});
      if (exp_rv0 && q0.size() > 0) last0 = q0.pop_front();
      if (exp_rv1 && q1.size() > 0) last1 = q1.pop_front();
      check_eq("p0_rdata", o_p0_rdata, last0);
      check_eq("p1_rdata", o_p1_rdata, last1);
   endtask

   // One arbitration cycle: starts and ends 1 time unit after a rising edge.
   task automatic run_cycle(input logic r0, input logic w0, input logic [63:0] a0, input logic [63:0] d0,
                            input logic r1, input logic w1, input logic [63:0] a1, input logic [63:0] d1);
      logic g0, g1, ewe;
      logic [9:0]  ea;
      logic [63:0] ewd;
      i_p0_req = r0; i_p0_we = w0; i_p0_addr = a0; i_p0_wdata = d0;
      i_p1_req = r1; i_p1_we = w1; i_p1_addr = a1; i_p1_wdata = d1;
      g1  = r1 && (!r0 || wait_m == MAX_WAIT);
      g0  = r0 && !g1;
      ea  = g0 ? a0[9:0] : (g1 ? a1[9:0] : 10'd0);
      ewe = g0 ? w0 : (g1 ? w1 : 1'b0);
      ewd = g0 ? d0 : (g1 ? d1 : 64'd0);
      #3;
      check_eq("p0_stall", {63'd0, o_p0_stall}, {63'd0, r0 && !g0});
      check_eq("p1_gnt", {63'd0, o_p1_gnt}, {63'd0, g1});
      check_eq("mem_we", {63'd0, o_mem_we}, {63'd0, ewe});
      check_eq("mem_addr", {54'd0, o_mem_addr}, {54'd0, ea});
      check_eq("mem_wdata", o_mem_wdata, ewd);
      exp_rv0 = g0 && !w0;
      exp_rv1 = g1 && !w1;
      if (exp_rv0) q0.push_back(model_read(ea));
      if (exp_rv1) q1.push_back(model_read(ea));
      if (ewe) begin
         model_mem[ea] = ewd;
         model_wr[ea]  = 1'b1;
      end
      wait_m = (r1 && !g1) ? ((wait_m >= MAX_WAIT) ? MAX_WAIT : wait_m + 1) : 0;
      @(posedge clk); #1;
      check_returns();
   endtask

   task automatic model_reset();
      wait_m = 0; last0 = 64'd0; last1 = 64'd0;
      q0.delete(); q1.delete();
   endtask

   initial begin
      model_wr = '0;
      i_arst = 1'b0;
      i_p0_req = 1'b0; i_p0_we = 1'b0; i_p0_addr = 64'd0; i_p0_wdata = 64'd0;
      i_p1_req = 1'b0; i_p1_we = 1'b0; i_p1_addr = 64'd0; i_p1_wdata = 64'd0;
      model_reset();

      // Reset held with both ports reading.
      @(posedge clk); #1;
      i_p0_req = 1'b1; i_p0_addr = 64'h20; i_p1_req = 1'b1; i_p1_addr = 64'h30;
      #2;
      check_eq("rst_mem_addr", {54'd0, o_mem_addr}, 64'h20);
      check_eq("rst_mem_we", {63'd0, o_mem_we}, 64'd0);
      check_eq("rst_p1_gnt", {63'd0, o_p1_gnt}, 64'd0);
      @(posedge clk); #1;
      check_eq("rst_p0_rvalid", {63'd0, o_p0_rvalid}, 64'd0);
      check_eq("rst_p1_rvalid", {63'd0, o_p1_rvalid}, 64'd0);
      check_eq("rst_p0_rdata", o_p0_rdata, 64'd0);
      check_eq("rst_p1_rdata", o_p1_rdata, 64'd0);
      i_arst = 1'b1; i_p0_req = 1'b0; i_p1_req = 1'b0;

      // Single p0 read returns the memory word one cycle later.
      run_cycle(1'b1, 1'b0, 64'h10, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0);
      check_eq("p0_read_dead", o_p0_rdata, 64'hDEAD);

      // Contention: p1 wins every fifth cycle.
      for (int i = 0; i < 11; i++)
         run_cycle(1'b1, 1'b0, 64'h100 + 64'(i * 8), 64'd0, 1'b1, 1'b0, 64'h200 + 64'(i * 8), 64'd0);
      // Dropping p1 request clears the counter.
      for (int i = 0; i < 9; i++)
         run_cycle(1'b1, 1'b0, 64'h50, 64'd0, (i != 3), 1'b0, 64'h60, 64'd0);

      // p1 write alone, then p0 read through a wrapped address.
      run_cycle(1'b0, 1'b0, 64'd0, 64'd0, 1'b1, 1'b1, 64'h08, 64'h55);
      run_cycle(1'b1, 1'b0, 64'h408, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0);
      check_eq("wrap_read", o_p0_rdata, 64'h55);
      run_cycle(1'b0, 1'b0, 64'd0, 64'd0, 1'b1, 1'b0, 64'hFFFF_0000_0000_0408, 64'd0);

      // Alternating back-to-back ports, wide data, both-write contention and idle bus.
      run_cycle(1'b1, 1'b1, 64'h3F0, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, 64'd0, 64'd0);
      run_cycle(1'b0, 1'b0, 64'd0, 64'd0, 1'b1, 1'b0, 64'h3F0, 64'd0);
      run_cycle(1'b1, 1'b1, 64'h3F8, 64'hAAAA_5555_AAAA_5555, 1'b1, 1'b1, 64'h3F0, 64'hFEED);
      run_cycle(1'b0, 1'b0, 64'd0, 64'd0, 1'b1, 1'b1, 64'h3F0, 64'hFEED);
      run_cycle(1'b1, 1'b0, 64'h3F0, 64'd0, 1'b1, 1'b0, 64'h3F8, 64'd0);
      run_cycle(1'b0, 1'b1, 64'h55, 64'hFF, 1'b0, 1'b1, 64'h66, 64'hEE);

      // Reset while a read return is pending and another read is granted.
      run_cycle(1'b1, 1'b0, 64'h40, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0);
      i_p0_req = 1'b1; i_p0_we = 1'b0; i_p0_addr = 64'h48;
      #1 i_arst = 1'b0;
      #1;
      check_eq("midrst_p0_rvalid", {63'd0, o_p0_rvalid}, 64'd0);
      check_eq("midrst_p0_rdata", o_p0_rdata, 64'd0);
      @(posedge clk); #1;
      check_eq("midrst_p0_rvalid_hold", {63'd0, o_p0_rvalid}, 64'd0);
      i_arst = 1'b1; i_p0_req = 1'b0;
      model_reset();
      run_cycle(1'b1, 1'b0, 64'h10, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0);

      // Random traffic.
      for (int i = 0; i < 60; i++)
         run_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
                   1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom});

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
